// File: rtl/result_tx_ctrl_pkg.sv
// result_tx_ctrl_pkg: shared widths, exponent field position and FIFO entry type for the result transmit path.
package result_tx_ctrl_pkg;
   localparam int LINE_W         = 128;
   localparam int WORD_W         = 256;
   localparam int EXP_MSB        = 14;
   localparam int EXP_LSB        = 7;
   localparam int FIFO_DEPTH_DEF = 16;
   typedef struct packed {
      logic              last;
      logic [WORD_W-1:0] data;
   } fifo_entry_t;
endpackage

// File: rtl/result_tx_ctrl_if.sv
// result_tx_ctrl_if: line input and packed-word output handshake of the result transmitter.
interface result_tx_ctrl_if;
   import result_tx_ctrl_pkg::*;
   logic [LINE_W-1:0] in_data;
   logic              in_vld;
   logic [WORD_W-1:0] out_data;
   logic              out_vld;
   logic              out_ready;
   logic              out_last;
   modport master (output in_data, in_vld, out_ready, input out_data, out_vld, out_last);
   modport slave  (input in_data, in_vld, out_ready, output out_data, out_vld, out_last);
endinterface

// File: rtl/result_tx_ctrl_fifo.sv
// result_fifo: synchronous first-word fall-through FIFO of packed words plus last flag.
module result_fifo
   import result_tx_ctrl_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push_i,
   input  logic        pop_i,
   input  fifo_entry_t wdata_i,
   output fifo_entry_t rdata_o,
   output logic        full_o,
   output logic        empty_o,
   output logic [AW:0] level_o
);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   fifo_entry_t   mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   level_q;
   logic          do_push, do_pop;
   assign empty_o = level_q == '0;
   assign full_o  = level_q == FULL_LVL;
   assign level_o = level_q;
   // a pop frees the slot this cycle, so a full FIFO still accepts a simultaneous push
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = empty_o ? '0 : mem_q[rd_q];
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop) rd_q <= rd_q + AW'(1);
         level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/result_tx_ctrl.sv
// result_tx_ctrl: packs 128-bit result lines in pairs into 256-bit words queued for the sink.
// Define RESULT_TX_MAX_EXP_EN to add per-node maximum BF16 exponent reporting.
module result_tx_ctrl
   import result_tx_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int LINE_CNT_W = 11
) (
   input  logic                          clk,
   input  logic                          rst_n,
   result_tx_ctrl_if.slave               bus,
   input  logic [LINE_CNT_W-1:0]         num_of_line_per_node_minusone,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef RESULT_TX_MAX_EXP_EN
   ,
   output logic [7:0]                    max_exponent,
   output logic                          max_exponent_vld
`endif
);
   logic [LINE_CNT_W-1:0] cnt_q, cnt_d, n_q, n_d, n_eff;
   logic [LINE_W-1:0]     half_q, half_d;
   logic                  phase_q, phase_d, ovf_q, ovf_d;
   logic                  line_last, push, full, empty;
   fifo_entry_t           wr_e, rd_e;
   always_comb begin
      n_eff     = (cnt_q == '0) ? num_of_line_per_node_minusone : n_q;
      line_last = cnt_q == n_eff;
      push      = bus.in_vld && (phase_q || line_last);
      wr_e.last = line_last;
      wr_e.data = phase_q ? {bus.in_data, half_q} : {{LINE_W{1'b0}}, bus.in_data};
      n_d       = (bus.in_vld && cnt_q == '0) ? num_of_line_per_node_minusone : n_q;
      cnt_d     = !bus.in_vld ? cnt_q : line_last ? '0 : cnt_q + LINE_CNT_W'(1);
      phase_d   = !bus.in_vld ? phase_q : !line_last && !phase_q;
      half_d    = (bus.in_vld && !phase_q) ? bus.in_data : half_q;
      ovf_d     = ovf_q || (push && full && !bus.out_ready);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         n_q     <= '0;
         phase_q <= 1'b0;
         half_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         n_q     <= n_d;
         phase_q <= phase_d;
         half_q  <= half_d;
         ovf_q   <= ovf_d;
      end
   end
   result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (bus.out_ready),
      .wdata_i (wr_e),
      .rdata_o (rd_e),
      .full_o  (full),
      .empty_o (empty),
      .level_o (fifo_level)
   );
   assign bus.out_vld  = !empty;
   assign bus.out_data = rd_e.data;
   assign bus.out_last = rd_e.last;
   assign overflow     = ovf_q;
`ifdef RESULT_TX_MAX_EXP_EN
   logic [7:0] mx_q, mx_d, mexp_q, mexp_d, exp_in, cand;
   logic       mv_q, mv_d;
   // running max restarts at zero so a line in the pulse cycle opens the next node
   always_comb begin
      exp_in = bus.in_data[EXP_MSB:EXP_LSB];
      cand   = (exp_in > mx_q) ? exp_in : mx_q;
      mx_d   = !bus.in_vld ? mx_q : line_last ? 8'h00 : cand;
      mexp_d = (bus.in_vld && line_last) ? cand : mexp_q;
      mv_d   = bus.in_vld && line_last;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mx_q   <= 8'h00;
         mexp_q <= 8'h00;
         mv_q   <= 1'b0;
      end else begin
         mx_q   <= mx_d;
         mexp_q <= mexp_d;
         mv_q   <= mv_d;
      end
   end
   assign max_exponent     = mexp_q;
   assign max_exponent_vld = mv_q;
`endif
endmodule

// File: tb/tb_result_tx_ctrl.sv
// tb_result_tx_ctrl: scoreboard bench for result_tx_ctrl (optionally with RESULT_TX_MAX_EXP_EN).
module tb_result_tx_ctrl;
   import result_tx_ctrl_pkg::*;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [10:0] n_minus1;
   logic        overflow;
   logic [4:0]  fifo_level;
   int          n_cmp = 0, n_bad = 0;
   logic [256:0] sb[$];
   result_tx_ctrl_if bus();
`ifdef RESULT_TX_MAX_EXP_EN
   logic [7:0] max_exponent, last_mexp;
   logic       max_exponent_vld;
   int         pulses = 0;
`endif
   always #5 clk = ~clk;
   result_tx_ctrl #(.FIFO_DEPTH(16), .LINE_CNT_W(11)) dut (
      .clk                           (clk),
      .rst_n                         (rst_n),
      .bus                           (bus),
      .num_of_line_per_node_minusone (n_minus1),
      .overflow                      (overflow),
      .fifo_level                    (fifo_level)
`ifdef RESULT_TX_MAX_EXP_EN
      ,
      .max_exponent                  (max_exponent),
      .max_exponent_vld              (max_exponent_vld)
`endif
   );
   task automatic chk(input string nm, input logic [256:0] act, input logic [256:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   function automatic logic [256:0] w(input logic last, input logic [127:0] hi, input logic [127:0] lo);
      return {last, hi, lo};
   endfunction
   task automatic line(input logic [127:0] d);
      bus.in_data = d;
      bus.in_vld  = 1'b1;
      @(posedge clk);
      #1 bus.in_vld = 1'b0;
   endtask
   task automatic drain(input string nm);
      int k = 0;
      while (sb.size() != 0 && k < 300) begin
         @(posedge clk);
         k++;
      end
      repeat (2) @(negedge clk);
      chk({nm, "_drained"}, 257'(sb.size()), 257'd0);
      chk({nm, "_vld_after_drain"}, 257'(bus.out_vld), 257'd0);
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin
      if (rst_n && bus.out_vld && bus.out_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_word: got %h expected none", {bus.out_last, bus.out_data});
         end else chk("word", {bus.out_last, bus.out_data}, sb.pop_front());
      end
`ifdef RESULT_TX_MAX_EXP_EN
      if (max_exponent_vld) begin
         pulses++;
         last_mexp = max_exponent;
      end
`endif
   end
   initial begin
      #600000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      bus.in_data = '0;
      bus.in_vld = 1'b0;
      bus.out_ready = 1'b0;
      n_minus1 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_vld", 257'(bus.out_vld), 257'd0);
      chk("rst_out_last", 257'(bus.out_last), 257'd0);
      chk("rst_out_data", 257'(bus.out_data), 257'd0);
      chk("rst_overflow", 257'(overflow), 257'd0);
      chk("rst_level", 257'(fifo_level), 257'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // even node: first word visible the cycle after its second line
      n_minus1 = 11'd3;
      bus.out_ready = 1'b1;
      sb.push_back(w(1'b0, 128'h2, 128'h1));
      sb.push_back(w(1'b1, 128'h4, 128'h3));
      line(128'h1);
      chk("lat_after_line1", 257'(bus.out_vld), 257'd0);
      line(128'h2);
      chk("lat_after_line2", 257'(bus.out_vld), 257'd1);
      line(128'h3);
      line(128'h4);
      drain("even");
      // odd node then a fresh pair
      n_minus1 = 11'd2;
      sb.push_back(w(1'b0, 128'hB0B, 128'hA0A));
      sb.push_back(w(1'b1, 128'h0, 128'hC0C));
      sb.push_back(w(1'b1, 128'hE0E, 128'hD0D));
      line(128'hA0A);
      line(128'hB0B);
      line(128'hC0C);
      n_minus1 = 11'd1;
      line(128'hD0D);
      line(128'hE0E);
      drain("odd");
      // overflow: 34 lines, sink stalled, only the first 16 words survive
      bus.out_ready = 1'b0;
      n_minus1 = 11'd33;
      for (int k = 0; k < 16; k++) sb.push_back(w(1'b0, 128'(32'h101 + 2*k), 128'(32'h100 + 2*k)));
      for (int i = 0; i < 34; i++) line(128'(32'h100 + i));
      chk("ovf_level", 257'(fifo_level), 257'd16);
      chk("ovf_flag", 257'(overflow), 257'd1);
      chk("ovf_hold_data", 257'(bus.out_data), 257'({128'h101, 128'h100}));
      chk("ovf_hold_last", 257'(bus.out_last), 257'd0);
      bus.out_ready = 1'b1;
      drain("ovf");
      chk("ovf_sticky", 257'(overflow), 257'd1);
      rst_n = 1'b0;
      #1;
      chk("ovf_rst_clear", 257'(overflow), 257'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      // full with simultaneous push and pop
      bus.out_ready = 1'b0;
      n_minus1 = 11'd31;
      for (int k = 0; k < 16; k++) sb.push_back(w(k == 15, 128'(32'h201 + 2*k), 128'(32'h200 + 2*k)));
      for (int i = 0; i < 32; i++) line(128'(32'h200 + i));
      chk("full_level", 257'(fifo_level), 257'd16);
      chk("full_no_ovf", 257'(overflow), 257'd0);
      n_minus1 = 11'd1;
      sb.push_back(w(1'b1, 128'h301, 128'h300));
      line(128'h300);
      bus.out_ready = 1'b1;
      line(128'h301);
      chk("pushpop_level", 257'(fifo_level), 257'd16);
      chk("pushpop_no_ovf", 257'(overflow), 257'd0);
      drain("pushpop");
      // reset mid-pair with a queued word
      bus.out_ready = 1'b0;
      n_minus1 = 11'd1;
      line(128'h400);
      line(128'h401);
      line(128'h500);
      chk("pre_rst_vld", 257'(bus.out_vld), 257'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", 257'(bus.out_vld), 257'd0);
      chk("mid_rst_last", 257'(bus.out_last), 257'd0);
      chk("mid_rst_data", 257'(bus.out_data), 257'd0);
      chk("mid_rst_level", 257'(fifo_level), 257'd0);
      chk("mid_rst_ovf", 257'(overflow), 257'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      sb.push_back(w(1'b1, 128'h601, 128'h600));
      line(128'h600);
      line(128'h601);
      drain("post_rst");
`ifdef RESULT_TX_MAX_EXP_EN
      begin
         int p0;
         p0 = pulses;
         n_minus1 = 11'd3;
         sb.push_back(w(1'b0, 128'(16'h85 << 7), 128'(16'h10 << 7)));
         sb.push_back(w(1'b1, 128'(16'h20 << 7), 128'(16'h7F << 7)));
         line(128'(16'h10 << 7));
         line(128'(16'h85 << 7));
         line(128'(16'h7F << 7));
         line(128'(16'h20 << 7));
         drain("maxexp");
         chk("maxexp_pulses", 257'(pulses - p0), 257'd1);
         chk("maxexp_value", 257'(last_mexp), 257'h85);
      end
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
